bypass_network: RTL and testbench
=================================

// Module: bypass_network
// PURPOSE
// - Generalised EX-stage operand bypass for N_PORT source operands and N_SRC in-flight producers.
// - Producers are ordered 0 = youngest (DM1) to N_SRC-1 = oldest (WB).
// - Per-source DATA_READY replaces the fixed load-type check; a not-ready match raises LOAD_USE_HAZARD.
// - Stall-capture register per port holds forwarded data while the EX stage is stalled.
// - Sits between the ID/EX pipeline register and the ALU operand inputs.
// PARAMETERS
// DATA_WIDTH     32  operand / result width
// REG_ADD_WIDTH  5   register address width
// N_SRC          4   forwarding sources, 2..8
// N_PORT         2   source operands, 1..3
// CNT_WIDTH      16  hazard statistics counter width
// PORTS
// CLK                    in   1                     clock, rising edge
// RST                    in   1                     synchronous reset, active-high
// STALL_EXECUTION_STAGE  in   1                     EX held this cycle
// FLUSH_EXECUTION_STAGE  in   1                     EX instruction killed; clears captures
// RS_ADDRESS             in   N_PORT*REG_ADD_WIDTH  operand register addresses, port p at [p*RAW +: RAW]
// RS_USED                in   N_PORT                port p is actually read by the instruction
// RS_DATA_EXECUTION      in   N_PORT*DATA_WIDTH     register-file values latched at decode
// SRC_RD_ADDRESS         in   N_SRC*REG_ADD_WIDTH   destination address of source s
// SRC_WRITE_ENABLE       in   N_SRC                 source s writes rd
// SRC_DATA_READY         in   N_SRC                 source s result valid; 0 = load in flight
// SRC_RD_DATA            in   N_SRC*DATA_WIDTH      result of source s
// RS_DATA                out  N_PORT*DATA_WIDTH     resolved operands
// RS_FORWARDED           out  N_PORT                port p is not using RS_DATA_EXECUTION
// LOAD_USE_HAZARD        out  1                     EX must stall: a used port's youngest match is not ready
// HAZARD_COUNT           out  CNT_WIDTH             saturating count of hazard cycles
// BEHAVIOUR
// Match and selection
// - match[p][s] = SRC_WRITE_ENABLE[s] & (SRC_RD_ADDRESS[s] == RS_ADDRESS[p]) & (RS_ADDRESS[p] != 0).
// - x0 is never forwarded.
// - Select the lowest-index matching source (youngest wins), whether or not it is ready.
// - If the selected source is ready: live value = SRC_RD_DATA[s], live_hit = 1.
// - If the selected source is not ready: live_hit = 0 and pend[p] = RS_USED[p].
// Operand mux (combinational, zero latency), per port
// - live_hit                  -> live value
// - else cap_valid[p]         -> cap_data[p]
// - else                      -> RS_DATA_EXECUTION[p]
// - RS_FORWARDED[p] = live_hit | cap_valid[p].
// - LOAD_USE_HAZARD = OR over p of pend[p].
// - Outputs are don't-care while LOAD_USE_HAZARD = 1, except LOAD_USE_HAZARD itself.
// Capture (rising CLK, per port)
// - RST, or FLUSH, or !STALL: cap_valid <= 0, cap_data <= 0.  FLUSH has priority over STALL.
// - STALL & live_hit: cap_data <= live value, cap_valid <= 1.  Refreshed every stall cycle.
// - STALL & !live_hit: hold.  The producer has retired from WB during the stall.
// - In-order pipeline guarantee: no older producer can match after a younger one retires,
//   so a live hit always supersedes the capture.
// Counter
// - RST -> 0.
// - Increments once per cycle with LOAD_USE_HAZARD = 1.
// - Saturates at all-ones; no wrap.
// Reset values
// - cap_valid = 0, cap_data = 0, HAZARD_COUNT = 0.
// - RS_DATA, RS_FORWARDED and LOAD_USE_HAZARD are combinational on inputs.
// - RST mid-stall drops captures; the next cycle falls back to RS_DATA_EXECUTION.
// STRUCTURE
// - forwarding_pkg: constants SRC_DM1 = 0, SRC_WB = N_SRC-1, ZERO_REG = '0, and the
//   slice helper functions for the packed port buses.
// - Sub-module bypass_port_select, instantiated N_PORT times by generate.
//   Contains the priority encoder, live/pend logic, capture register and operand mux.
// - Top level: generate loop, hazard OR-reduce, saturating counter.
// TESTING
// 1 RS_ADDRESS[0]=5; sources 1 and 3 write x5 ready with 0xAAAA / 0xBBBB
//   -> RS_DATA[0]=0xAAAA, RS_FORWARDED[0]=1.
// 2 RS_ADDRESS[1]=0; source 0 writes x0 = 0x1234
//   -> RS_DATA[1]=RS_DATA_EXECUTION[1], RS_FORWARDED[1]=0.
// 3 RS_USED[0]=1, source 0 writes x7 with DATA_READY=0 -> LOAD_USE_HAZARD=1, HAZARD_COUNT +1/cycle.
//   Same with RS_USED[0]=0 -> LOAD_USE_HAZARD=0.
// 4 STALL=1 for 3 cycles; WB forwards x9 = 0xCAFE in cycle 0, then retires
//   -> RS_DATA=0xCAFE in cycles 1-2; STALL=0 next cycle -> capture cleared.
// 5 Stall with capture valid, then FLUSH=1 with STALL=1
//   -> next cycle cap_valid=0, output = RS_DATA_EXECUTION.
// 6 CNT_WIDTH=4, hold hazard 20 cycles -> HAZARD_COUNT saturates at 0xF.
//   RST -> 0 on next edge.

Source files
------------

// File: rtl/forwarding_pkg.sv
// Shared constants and bus-slicing helpers for the EX-stage operand bypass.
package forwarding_pkg;

  localparam int SRC_DM1  = 0;
  localparam int ZERO_REG = 0;

  // Producers are ordered youngest first, so the oldest (WB) sits at the top.
  function automatic int src_wb(input int n_src);
    return n_src - 1;
  endfunction

  function automatic int slice_lsb(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/bypass_port_select.sv
// One operand port: youngest-match priority select, load-use detect,
// stall-capture register and final operand mux.
module bypass_port_select
  import forwarding_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int REG_ADD_WIDTH = 5,
  parameter int N_SRC         = 4
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          STALL_EXECUTION_STAGE,
  input  logic                          FLUSH_EXECUTION_STAGE,
  input  logic [REG_ADD_WIDTH-1:0]      RS_ADDRESS,
  input  logic                          RS_USED,
  input  logic [DATA_WIDTH-1:0]         RS_DATA_EXECUTION,
  input  logic [N_SRC*REG_ADD_WIDTH-1:0] SRC_RD_ADDRESS,
  input  logic [N_SRC-1:0]              SRC_WRITE_ENABLE,
  input  logic [N_SRC-1:0]              SRC_DATA_READY,
  input  logic [N_SRC*DATA_WIDTH-1:0]   SRC_RD_DATA,
  output logic [DATA_WIDTH-1:0]         RS_DATA,
  output logic                          RS_FORWARDED,
  output logic                          PEND
);

  logic                  sel_hit;
  logic                  sel_ready;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  live_hit;
  logic                  cap_valid;
  logic [DATA_WIDTH-1:0] cap_data;

  // Scan oldest to youngest so the youngest match is the last one written.
  always_comb begin
    sel_hit   = 1'b0;
    sel_ready = 1'b0;
    sel_data  = '0;
    for (int s = src_wb(N_SRC); s >= SRC_DM1; s--) begin
      if (SRC_WRITE_ENABLE[s] &&
          SRC_RD_ADDRESS[slice_lsb(s, REG_ADD_WIDTH) +: REG_ADD_WIDTH] == RS_ADDRESS &&
          RS_ADDRESS != REG_ADD_WIDTH'(ZERO_REG)) begin
        sel_hit   = 1'b1;
        sel_ready = SRC_DATA_READY[s];
        sel_data  = SRC_RD_DATA[slice_lsb(s, DATA_WIDTH) +: DATA_WIDTH];
      end
    end
  end

  assign live_hit = sel_hit & sel_ready;
  assign PEND     = sel_hit & ~sel_ready & RS_USED;

  // A retired producer leaves no live hit; the capture carries its value
  // for the remainder of the stall.
  always_ff @(posedge CLK) begin
    if (RST || FLUSH_EXECUTION_STAGE || !STALL_EXECUTION_STAGE) begin
      cap_valid <= 1'b0;
      cap_data  <= '0;
    end else if (live_hit) begin
      cap_valid <= 1'b1;
      cap_data  <= sel_data;
    end
  end

  always_comb begin
    if (live_hit)       RS_DATA = sel_data;
    else if (cap_valid) RS_DATA = cap_data;
    else                RS_DATA = RS_DATA_EXECUTION;
  end

  assign RS_FORWARDED = live_hit | cap_valid;

endmodule

// File: rtl/bypass_network.sv
// EX-stage operand bypass: per-port select instances, hazard reduce and
// saturating hazard-cycle counter.
module bypass_network
  import forwarding_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int REG_ADD_WIDTH = 5,
  parameter int N_SRC         = 4,
  parameter int N_PORT        = 2,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic                            STALL_EXECUTION_STAGE,
  input  logic                            FLUSH_EXECUTION_STAGE,
  input  logic [N_PORT*REG_ADD_WIDTH-1:0] RS_ADDRESS,
  input  logic [N_PORT-1:0]               RS_USED,
  input  logic [N_PORT*DATA_WIDTH-1:0]    RS_DATA_EXECUTION,
  input  logic [N_SRC*REG_ADD_WIDTH-1:0]  SRC_RD_ADDRESS,
  input  logic [N_SRC-1:0]                SRC_WRITE_ENABLE,
  input  logic [N_SRC-1:0]                SRC_DATA_READY,
  input  logic [N_SRC*DATA_WIDTH-1:0]     SRC_RD_DATA,
  output logic [N_PORT*DATA_WIDTH-1:0]    RS_DATA,
  output logic [N_PORT-1:0]               RS_FORWARDED,
  output logic                            LOAD_USE_HAZARD,
  output logic [CNT_WIDTH-1:0]            HAZARD_COUNT
);

  logic [N_PORT-1:0] pend;

  for (genvar p = 0; p < N_PORT; p++) begin : g_port
    bypass_port_select #(
      .DATA_WIDTH   (DATA_WIDTH),
      .REG_ADD_WIDTH(REG_ADD_WIDTH),
      .N_SRC        (N_SRC)
    ) u_sel (
      .CLK                  (CLK),
      .RST                  (RST),
      .STALL_EXECUTION_STAGE(STALL_EXECUTION_STAGE),
      .FLUSH_EXECUTION_STAGE(FLUSH_EXECUTION_STAGE),
      .RS_ADDRESS           (RS_ADDRESS[p*REG_ADD_WIDTH +: REG_ADD_WIDTH]),
      .RS_USED              (RS_USED[p]),
      .RS_DATA_EXECUTION    (RS_DATA_EXECUTION[p*DATA_WIDTH +: DATA_WIDTH]),
      .SRC_RD_ADDRESS       (SRC_RD_ADDRESS),
      .SRC_WRITE_ENABLE     (SRC_WRITE_ENABLE),
      .SRC_DATA_READY       (SRC_DATA_READY),
      .SRC_RD_DATA          (SRC_RD_DATA),
      .RS_DATA              (RS_DATA[p*DATA_WIDTH +: DATA_WIDTH]),
      .RS_FORWARDED         (RS_FORWARDED[p]),
      .PEND                 (pend[p])
    );
  end

  assign LOAD_USE_HAZARD = |pend;

  always_ff @(posedge CLK) begin
    if (RST)
      HAZARD_COUNT <= '0;
    else if (LOAD_USE_HAZARD && HAZARD_COUNT != {CNT_WIDTH{1'b1}})
      HAZARD_COUNT <= HAZARD_COUNT + 1'b1;
  end

endmodule

// File: tb/tb_bypass_network.sv
// Directed bench for bypass_network: forwarding priority, x0, load-use,
// stall capture, flush, counter saturation and reset.
module tb_bypass_network;

  localparam int DW  = 32;
  localparam int RAW = 5;
  localparam int NS  = 4;
  localparam int NP  = 2;
  localparam int CW  = 4;

  logic                       CLK = 1'b0;
  logic                       RST;
  logic                       stall, flush;
  logic [NP-1:0][RAW-1:0]     rs_addr;
  logic [NP-1:0]              rs_used;
  logic [NP-1:0][DW-1:0]      rs_dex;
  logic [NS-1:0][RAW-1:0]     src_addr;
  logic [NS-1:0]              src_we, src_rdy;
  logic [NS-1:0][DW-1:0]      src_data;
  logic [NP-1:0][DW-1:0]      rs_data;
  logic [NP-1:0]              rs_fwd;
  logic                       hazard;
  logic [CW-1:0]              hcnt;

  int checks = 0;
  int fails  = 0;

  bypass_network #(
    .DATA_WIDTH(DW), .REG_ADD_WIDTH(RAW), .N_SRC(NS), .N_PORT(NP), .CNT_WIDTH(CW)
  ) dut (
    .CLK                  (CLK),
    .RST                  (RST),
    .STALL_EXECUTION_STAGE(stall),
    .FLUSH_EXECUTION_STAGE(flush),
    .RS_ADDRESS           (rs_addr),
    .RS_USED              (rs_used),
    .RS_DATA_EXECUTION    (rs_dex),
    .SRC_RD_ADDRESS       (src_addr),
    .SRC_WRITE_ENABLE     (src_we),
    .SRC_DATA_READY       (src_rdy),
    .SRC_RD_DATA          (src_data),
    .RS_DATA              (rs_data),
    .RS_FORWARDED         (rs_fwd),
    .LOAD_USE_HAZARD      (hazard),
    .HAZARD_COUNT         (hcnt)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic srcs_off();
    src_we   = '0;
    src_rdy  = '0;
    src_addr = '0;
    src_data = '0;
  endtask

  task automatic set_src(input int s, input logic [RAW-1:0] a, input logic [DW-1:0] d,
                         input logic rdy);
    src_we[s]   = 1'b1;
    src_addr[s] = a;
    src_data[s] = d;
    src_rdy[s]  = rdy;
  endtask

  initial begin
    RST = 1'b1; stall = 1'b0; flush = 1'b0;
    rs_addr = '0; rs_used = '0;
    rs_dex[0] = 32'h1111; rs_dex[1] = 32'h5555;
    srcs_off();
    tick(); tick();
    chk("rst_cnt", 64'(hcnt), 0);
    chk("rst_fwd", 64'(rs_fwd), 0);
    chk("rst_data0", 64'(rs_data[0]), 64'h1111);
    chk("rst_haz", 64'(hazard), 0);
    RST = 1'b0;
    tick();

    // youngest ready match wins
    rs_addr[0] = 5; rs_addr[1] = 6; rs_used = 2'b11;
    set_src(1, 5, 32'hAAAA, 1'b1);
    set_src(3, 5, 32'hBBBB, 1'b1);
    #1;
    chk("prio_data0", 64'(rs_data[0]), 64'hAAAA);
    chk("prio_fwd", 64'(rs_fwd), 64'b01);
    chk("nomatch_data1", 64'(rs_data[1]), 64'h5555);
    src_we[1] = 1'b0;
    #1;
    chk("oldest_data0", 64'(rs_data[0]), 64'hBBBB);
    tick();

    // x0 never forwarded, never hazards
    srcs_off();
    rs_addr[0] = 3; rs_addr[1] = 0;
    set_src(0, 0, 32'h1234, 1'b1);
    #1;
    chk("x0_data1", 64'(rs_data[1]), 64'h5555);
    chk("x0_fwd", 64'(rs_fwd), 0);
    src_rdy[0] = 1'b0;
    #1;
    chk("x0_nohaz", 64'(hazard), 0);
    tick();

    // load-use hazard and counting
    srcs_off();
    rs_addr[0] = 7; rs_addr[1] = 0;
    set_src(0, 7, 32'hDEAD, 1'b0);
    #1;
    chk("lu_haz", 64'(hazard), 1);
    chk("lu_cnt0", 64'(hcnt), 0);
    tick(); tick(); tick();
    chk("lu_cnt3", 64'(hcnt), 3);
    set_src(2, 7, 32'h7777, 1'b1);
    #1;
    chk("lu_shadow_haz", 64'(hazard), 1);
    tick();
    chk("lu_cnt4", 64'(hcnt), 4);
    rs_used[0] = 1'b0;
    #1;
    chk("lu_unused_haz", 64'(hazard), 0);
    tick();
    chk("lu_cnt_hold", 64'(hcnt), 4);
    rs_used = 2'b11;

    // stall capture across WB retirement
    srcs_off();
    rs_addr[0] = 9;
    stall = 1'b1;
    set_src(3, 9, 32'hCAFE, 1'b1);
    #1;
    chk("st_c0", 64'(rs_data[0]), 64'hCAFE);
    tick();
    srcs_off();
    #1;
    chk("st_c1", 64'(rs_data[0]), 64'hCAFE);
    chk("st_c1_fwd", 64'(rs_fwd[0]), 1);
    tick();
    chk("st_c2", 64'(rs_data[0]), 64'hCAFE);
    tick();
    stall = 1'b0;
    #1;
    chk("st_release", 64'(rs_data[0]), 64'hCAFE);
    tick();
    chk("st_cleared", 64'(rs_data[0]), 64'h1111);
    chk("st_cleared_fwd", 64'(rs_fwd[0]), 0);

    // flush drops capture even while stalled
    stall = 1'b1;
    set_src(1, 9, 32'hBEEF, 1'b1);
    tick();
    srcs_off();
    #1;
    chk("fl_cap", 64'(rs_data[0]), 64'hBEEF);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    chk("fl_data", 64'(rs_data[0]), 64'h1111);
    chk("fl_fwd", 64'(rs_fwd[0]), 0);
    stall = 1'b0;
    tick();

    // counter saturation then reset
    rs_addr[0] = 7;
    set_src(0, 7, 32'h0, 1'b0);
    repeat (10) tick();
    chk("sat_cnt14", 64'(hcnt), 14);
    repeat (10) tick();
    chk("sat_cnt15", 64'(hcnt), 15);
    srcs_off();
    RST = 1'b1;
    tick();
    chk("sat_rst", 64'(hcnt), 0);
    RST = 1'b0;

    // reset mid-stall drops capture
    stall = 1'b1;
    rs_addr[0] = 9;
    set_src(3, 9, 32'hD00D, 1'b1);
    tick();
    srcs_off();
    #1;
    chk("rs_cap", 64'(rs_data[0]), 64'hD00D);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    #1;
    chk("rs_data", 64'(rs_data[0]), 64'h1111);
    chk("rs_fwd", 64'(rs_fwd[0]), 0);
    stall = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
